// File: rtl/cache_nway_if.sv
// CPU request port and AXI-bridge rd/wr port of the N-way cache, bundled.
interface cache_nway_if #(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
);
  localparam int IDX_W = $clog2(SETS);
  localparam int OFF_W = $clog2(LINE_WORDS) + 2;
  localparam int TAG_W = 32 - IDX_W - OFF_W;

  // CPU side
  logic                    valid;
  logic                    op;
  logic                    uncached;
  logic [IDX_W-1:0]        index;
  logic [TAG_W-1:0]        tag;
  logic [OFF_W-1:0]        offset;
  logic [3:0]              wstrb;
  logic [31:0]             wdata;
  logic                    addr_ok;
  logic                    data_ok;
  logic [31:0]             rdata;
  // bridge side
  logic                    rd_req;
  logic [2:0]              rd_type;
  logic [31:0]             rd_addr;
  logic                    rd_rdy;
  logic                    ret_valid;
  logic                    ret_last;
  logic [31:0]             ret_data;
  logic                    wr_req;
  logic [2:0]              wr_type;
  logic [31:0]             wr_addr;
  logic [3:0]              wr_wstrb;
  logic [32*LINE_WORDS-1:0] wr_data;
  logic                    wr_rdy;

  // cache side
  modport slave (
    input  valid, op, uncached, index, tag, offset, wstrb, wdata,
    input  rd_rdy, ret_valid, ret_last, ret_data, wr_rdy,
    output addr_ok, data_ok, rdata,
    output rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data
  );

  // CPU + bridge side
  modport master (
    output valid, op, uncached, index, tag, offset, wstrb, wdata,
    output rd_rdy, ret_valid, ret_last, ret_data, wr_rdy,
    input  addr_ok, data_ok, rdata,
    input  rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data
  );
endinterface

// File: rtl/cache_nway.sv
// N-way set-associative write-back/write-allocate cache with uncached path.
// Replacement: lowest invalid way first, else per-set round-robin pointer.

// Per-way tag match.
module cache_nway_tagcmp #(
  parameter int TAG_W = 22
) (
  input  logic             vld,
  input  logic [TAG_W-1:0] tag_st,
  input  logic [TAG_W-1:0] tag_req,
  output logic             hit
);
  assign hit = vld && (tag_st == tag_req);
endmodule

module cache_nway #(
  parameter int WAYS       = 4,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic      clk,
  input  logic      reset,
  cache_nway_if.slave bus
);
  localparam int IDX_W  = $clog2(SETS);
  localparam int WSEL_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = WSEL_W + 2;
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOOKUP  = 3'd1;
  localparam logic [2:0] S_MISS    = 3'd2;
  localparam logic [2:0] S_REPLACE = 3'd3;
  localparam logic [2:0] S_REFILL  = 3'd4;
  localparam logic [2:0] S_UWRITE  = 3'd5;

  logic [2:0]        state;
  logic              r_op, r_unc;
  logic [IDX_W-1:0]  r_idx;
  logic [TAG_W-1:0]  r_tag;
  logic [OFF_W-1:0]  r_off;
  logic [3:0]        r_wstrb;
  logic [31:0]       r_wdata;
  logic [WAY_W-1:0]  victim;
  logic [WSEL_W-1:0] cnt;

  logic [WAY_W-1:0]  rr        [SETS];
  logic [SETS-1:0]   vld_arr   [WAYS];
  logic [SETS-1:0]   dirty_arr [WAYS];
  logic [TAG_W-1:0]  tag_arr   [WAYS][SETS];
  logic [31:0]       data_arr  [WAYS][SETS][LINE_WORDS];

  logic [WSEL_W-1:0] word;
  logic [WAYS-1:0]   hit_vec;
  logic              hit;
  logic [WAY_W-1:0]  hit_way, vic_c;
  logic [31:0]       line_addr, word_addr;

  assign word      = r_off[OFF_W-1:2];
  assign line_addr = {r_tag, r_idx, {OFF_W{1'b0}}};
  assign word_addr = {r_tag, r_idx, word, 2'b00};

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = be[b] ? nw[8*b +: 8] : old[8*b +: 8];
    return res;
  endfunction

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_nway_tagcmp #(.TAG_W(TAG_W)) u_cmp (
      .vld     (vld_arr[w][r_idx]),
      .tag_st  (tag_arr[w][r_idx]),
      .tag_req (r_tag),
      .hit     (hit_vec[w])
    );
  end

  // uncached requests must never hit, even when the line is resident
  assign hit = (|hit_vec) && !r_unc;

  // hit-way encode and victim pick; descending scan leaves the lowest index
  always_comb begin
    hit_way = '0;
    vic_c   = rr[r_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w])          hit_way = WAY_W'(w);
      if (!vld_arr[w][r_idx])  vic_c   = WAY_W'(w);
    end
  end

  // handshake and bus outputs, decoded from state
  always_comb begin
    bus.addr_ok  = (state == S_IDLE);
    bus.data_ok  = 1'b0;
    bus.rdata    = '0;
    bus.rd_req   = 1'b0;
    bus.rd_type  = 3'b100;
    bus.rd_addr  = line_addr;
    bus.wr_req   = 1'b0;
    bus.wr_type  = 3'b100;
    bus.wr_addr  = {tag_arr[victim][r_idx], r_idx, {OFF_W{1'b0}}};
    bus.wr_wstrb = 4'b1111;
    for (int w = 0; w < LINE_WORDS; w++) bus.wr_data[32*w +: 32] = data_arr[victim][r_idx][w];
    case (state)
      S_LOOKUP: if (hit) begin
        bus.data_ok = 1'b1;
        if (!r_op) bus.rdata = data_arr[hit_way][r_idx][word];
      end
      S_MISS: bus.wr_req = 1'b1;
      S_REPLACE: begin
        bus.rd_req = 1'b1;
        if (r_unc) begin
          bus.rd_type = 3'b010;
          bus.rd_addr = word_addr;
        end
      end
      S_REFILL: if (bus.ret_valid) begin
        if (r_unc || (!r_op && cnt == word)) begin
          bus.data_ok = 1'b1;
          bus.rdata   = bus.ret_data;
        end else if (r_op && bus.ret_last) begin
          bus.data_ok = 1'b1;
        end
      end
      S_UWRITE: begin
        bus.wr_req         = 1'b1;
        bus.wr_type        = 3'b010;
        bus.wr_addr        = word_addr;
        bus.wr_wstrb       = r_wstrb;
        bus.wr_data        = '0;
        bus.wr_data[31:0]  = r_wdata;
        bus.data_ok        = bus.wr_rdy;
      end
      default: ;
    endcase
  end

  // control FSM, request latch, valid/dirty/round-robin state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      r_op    <= 1'b0;
      r_unc   <= 1'b0;
      r_idx   <= '0;
      r_tag   <= '0;
      r_off   <= '0;
      r_wstrb <= '0;
      r_wdata <= '0;
      victim  <= '0;
      cnt     <= '0;
      for (int s = 0; s < SETS; s++) rr[s] <= '0;
      for (int w = 0; w < WAYS; w++) begin
        vld_arr[w]   <= '0;
        dirty_arr[w] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: if (bus.valid) begin
          r_op    <= bus.op;
          r_unc   <= bus.uncached;
          r_idx   <= bus.index;
          r_tag   <= bus.tag;
          r_off   <= bus.offset;
          r_wstrb <= bus.wstrb;
          r_wdata <= bus.wdata;
          state   <= S_LOOKUP;
        end
        S_LOOKUP: begin
          if (hit) begin
            if (r_op) dirty_arr[hit_way][r_idx] <= 1'b1;
            state <= S_IDLE;
          end else if (r_unc) begin
            state <= r_op ? S_UWRITE : S_REPLACE;
          end else begin
            victim <= vic_c;
            state  <= (vld_arr[vic_c][r_idx] && dirty_arr[vic_c][r_idx]) ? S_MISS : S_REPLACE;
          end
        end
        S_MISS:    if (bus.wr_rdy) state <= S_REPLACE;
        S_REPLACE: if (bus.rd_rdy) begin
          state <= S_REFILL;
          cnt   <= '0;
        end
        S_REFILL: if (bus.ret_valid) begin
          if (bus.ret_last) begin
            cnt   <= '0;
            state <= S_IDLE;
            if (!r_unc) begin
              vld_arr[victim][r_idx]   <= 1'b1;
              dirty_arr[victim][r_idx] <= r_op;
              rr[r_idx] <= (rr[r_idx] == WAY_W'(WAYS - 1)) ? '0 : rr[r_idx] + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_UWRITE: if (bus.wr_rdy) state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // tag/data arrays: store-hit merge and refill beats (store word merged in flight)
  always_ff @(posedge clk) begin
    if (state == S_LOOKUP && hit && r_op)
      data_arr[hit_way][r_idx][word] <= merge(data_arr[hit_way][r_idx][word], r_wdata, r_wstrb);
    if (state == S_REFILL && bus.ret_valid && !r_unc) begin
      data_arr[victim][r_idx][cnt] <= (r_op && cnt == word) ?
                                      merge(bus.ret_data, r_wdata, r_wstrb) : bus.ret_data;
      if (bus.ret_last) tag_arr[victim][r_idx] <= r_tag;
    end
  end
endmodule

// File: tb/tb_cache_nway.sv
// Table-driven bench for cache_nway: flat-memory reference model, bridge model
// with its own backing store, and a scoreboard of expected load data.
module tb_cache_nway;
  localparam int WAYS = 4, SETS = 64, LW = 4;
  localparam int IDX_W = $clog2(SETS);
  localparam int OFF_W = $clog2(LW) + 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cache_nway_if #(.SETS(SETS), .LINE_WORDS(LW)) bus ();
  cache_nway #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int compared = 0, mismatched = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // memories: bmem = bridge backing store, rmem = what the CPU should observe
  logic [31:0] bmem [logic [31:0]];
  logic [31:0] rmem [logic [31:0]];

  function automatic logic [31:0] dflt(input logic [31:0] a); return a ^ 32'hC0DE_0000; endfunction
  function automatic logic [31:0] brd(input logic [31:0] a); return bmem.exists(a) ? bmem[a] : dflt(a); endfunction
  function automatic logic [31:0] rrd(input logic [31:0] a); return rmem.exists(a) ? rmem[a] : dflt(a); endfunction
  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction
  function automatic logic [31:0] mk(input logic [21:0] t, input logic [5:0] i, input logic [3:0] o);
    return {t, i, o};
  endfunction
  task automatic preset(input logic [31:0] a, input logic [31:0] d);
    bmem[a] = d;
    rmem[a] = d;
  endtask

  // bridge model: one beat per cycle after the read request is taken
  int rd_count = 0, wr_count = 0, beats_left = 0, beat_i = 0;
  logic [31:0] rd_base, last_rd_addr, last_wr_addr;
  logic [2:0]  last_rd_type, last_wr_type;
  logic [3:0]  last_wr_wstrb;
  logic [32*LW-1:0] last_wr_data;

  initial begin
    bus.rd_rdy = 1'b1; bus.wr_rdy = 1'b1;
    bus.ret_valid = 1'b0; bus.ret_last = 1'b0; bus.ret_data = '0;
    forever begin
      @(negedge clk);
      bus.ret_valid = 1'b0; bus.ret_last = 1'b0; bus.ret_data = '0;
      if (reset) begin
        beats_left = 0;
      end else if (beats_left > 0) begin
        bus.ret_valid = 1'b1;
        bus.ret_data  = brd(rd_base + 32'(4 * beat_i));
        bus.ret_last  = (beats_left == 1);
        beat_i++;
        beats_left--;
      end else if (bus.rd_req === 1'b1 && bus.rd_rdy) begin
        rd_count++;
        rd_base = bus.rd_addr; last_rd_addr = bus.rd_addr; last_rd_type = bus.rd_type;
        beats_left = (bus.rd_type == 3'b100) ? LW : 1;
        beat_i = 0;
      end
      if (!reset && bus.wr_req === 1'b1 && bus.wr_rdy) begin
        wr_count++;
        last_wr_addr = bus.wr_addr; last_wr_type = bus.wr_type;
        last_wr_wstrb = bus.wr_wstrb; last_wr_data = bus.wr_data;
        if (bus.wr_type == 3'b100)
          for (int w = 0; w < LW; w++) bmem[bus.wr_addr + 32'(4 * w)] = bus.wr_data[32*w +: 32];
        else
          bmem[bus.wr_addr] = mrg(brd(bus.wr_addr), bus.wr_data[31:0], bus.wr_wstrb);
      end
    end
  end

  // scoreboard: popped on every data_ok
  typedef struct { bit is_load; logic [31:0] exp; } sb_t;
  sb_t sbq[$];
  int  done_cnt = 0;
  time done_t;
  logic ok_last;

  initial begin
    sb_t e;
    forever begin
      @(negedge clk); #2;
      if (bus.data_ok === 1'b1) begin
        done_cnt++; done_t = $time; ok_last = bus.ret_last;
        if (sbq.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL spurious data_ok: got data_ok=1 expected no pending request");
        end else begin
          e = sbq.pop_front();
          if (e.is_load) chk("rdata", bus.rdata, e.exp);
        end
      end
    end
  end

  // one CPU access, run to data_ok
  int  d_rd, d_wr;
  time t0;
  task automatic access(input bit o, input bit u, input logic [31:0] a,
                        input logic [3:0] ws, input logic [31:0] wd);
    int rd0, wr0, n0, k;
    sb_t e;
    k = 0;
    while (bus.addr_ok !== 1'b1 && k < 100) begin @(posedge clk); #1; k++; end
    if (bus.addr_ok !== 1'b1) begin
      compared++; mismatched++;
      $display("FAIL addr_ok wait: got %b expected 1", bus.addr_ok);
    end
    rd0 = rd_count; wr0 = wr_count; n0 = done_cnt;
    bus.valid = 1'b1; bus.op = o; bus.uncached = u;
    bus.tag = a[31:IDX_W+OFF_W]; bus.index = a[IDX_W+OFF_W-1:OFF_W]; bus.offset = a[OFF_W-1:0];
    bus.wstrb = ws; bus.wdata = wd;
    e.is_load = !o;
    e.exp = rrd({a[31:2], 2'b00});
    if (o) rmem[{a[31:2], 2'b00}] = mrg(e.exp, wd, ws);
    sbq.push_back(e);
    @(posedge clk); t0 = $time;
    #1 bus.valid = 1'b0;
    k = 0;
    while (done_cnt == n0 && k < 200) begin @(posedge clk); k++; end
    #1;
    if (done_cnt == n0) begin
      compared++; mismatched++;
      $display("FAIL data_ok timeout: got none expected data_ok for %0h", a);
      sbq.delete();
    end
    d_rd = rd_count - rd0;
    d_wr = wr_count - wr0;
  endtask

  typedef struct {
    bit op; bit unc; logic [31:0] addr; logic [3:0] ws; logic [31:0] wd;
    int miss; int wb; logic [31:0] wb_addr;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t V(input bit op, input bit unc, input logic [31:0] a, input logic [3:0] ws,
                             input logic [31:0] wd, input int miss, input int wb, input logic [31:0] wba);
    vec_t v;
    v.op = op; v.unc = unc; v.addr = a; v.ws = ws; v.wd = wd;
    v.miss = miss; v.wb = wb; v.wb_addr = wba;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    logic [31:0] exp_ra;
    access(v.op, v.unc, v.addr, v.ws, v.wd);
    chk({nm, " rd_req count"}, d_rd, v.miss);
    chk({nm, " wr_req count"}, d_wr, v.wb);
    if (v.miss != 0) begin
      exp_ra = v.unc ? {v.addr[31:2], 2'b00} : {v.addr[31:OFF_W], {OFF_W{1'b0}}};
      chk({nm, " rd_addr"}, last_rd_addr, exp_ra);
      chk({nm, " rd_type"}, last_rd_type, v.unc ? 3'b010 : 3'b100);
    end else if (!v.unc) begin
      chk({nm, " hit latency"}, done_t - t0, 7);
    end
    if (v.wb != 0) begin
      chk({nm, " wr_addr"}, last_wr_addr, v.wb_addr);
      chk({nm, " wr_type"}, last_wr_type, v.unc ? 3'b010 : 3'b100);
      chk({nm, " wr_wstrb"}, last_wr_wstrb, v.unc ? v.ws : 4'b1111);
      if (v.unc)
        chk({nm, " wr_data"}, last_wr_data, {{(32*LW-32){1'b0}}, v.wd});
      else
        for (int w = 0; w < LW; w++)
          chk($sformatf("%s wr_data w%0d", nm, w), last_wr_data[32*w +: 32], rrd(v.wb_addr + 32'(4 * w)));
    end
    if (v.op && !v.unc && v.miss != 0) chk({nm, " store data_ok on ret_last"}, ok_last, 1'b1);
  endtask

  localparam logic [21:0] TA = 22'h12345, T1 = 22'h00111, T2 = 22'h00222,
                          T3 = 22'h00333, T4 = 22'h00444, T5 = 22'h00555;

  initial begin
    logic [31:0] a, ua;
    int k;
    bus.valid = 1'b0; bus.op = 1'b0; bus.uncached = 1'b0;
    bus.index = '0; bus.tag = '0; bus.offset = '0; bus.wstrb = '0; bus.wdata = '0;
    #1 reset = 1'b1;
    #2;
    chk("reset addr_ok", bus.addr_ok, 1'b1);
    chk("reset data_ok", bus.data_ok, 1'b0);
    chk("reset rd_req", bus.rd_req, 1'b0);
    chk("reset wr_req", bus.wr_req, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1 reset = 1'b0;

    a  = mk(TA, 6'd5, 4'h8);
    ua = 32'hBFAF_0010;
    for (int w = 0; w < LW; w++) begin
      preset(mk(TA, 6'd5, 4'(4 * w)), 32'hA0 + 32'(w));
      preset(mk(T1, 6'd9, 4'(4 * w)), 32'h1111_1111);
    end

    vt.push_back(V(0, 0, a, 4'h0, 0, 1, 0, 0));                       // cold miss, word 2
    vt.push_back(V(0, 0, a, 4'h0, 0, 0, 0, 0));                       // hit
    vt.push_back(V(1, 0, a, 4'b0011, 32'hFFFF_BEEF, 0, 0, 0));        // store hit
    vt.push_back(V(0, 0, a, 4'h0, 0, 0, 0, 0));                       // merged read-back
    vt.push_back(V(0, 0, mk(T1, 5, 4'h0), 4'h0, 0, 1, 0, 0));
    vt.push_back(V(0, 0, mk(T2, 5, 4'h4), 4'h0, 0, 1, 0, 0));
    vt.push_back(V(0, 0, mk(T3, 5, 4'hC), 4'h0, 0, 1, 0, 0));
    vt.push_back(V(0, 0, mk(T4, 5, 4'h0), 4'h0, 0, 1, 1, mk(TA, 5, 0))); // rr=0: dirty way 0 out
    vt.push_back(V(0, 0, mk(T5, 5, 4'h0), 4'h0, 0, 1, 0, 0));         // rr=1: way 1 (T1) out
    vt.push_back(V(0, 0, mk(T2, 5, 4'h4), 4'h0, 0, 0, 0, 0));
    vt.push_back(V(0, 0, mk(T3, 5, 4'hC), 4'h0, 0, 0, 0, 0));
    vt.push_back(V(0, 0, mk(T4, 5, 4'h0), 4'h0, 0, 0, 0, 0));
    vt.push_back(V(0, 0, mk(T5, 5, 4'h0), 4'h0, 0, 0, 0, 0));
    vt.push_back(V(0, 0, mk(T1, 5, 4'h0), 4'h0, 0, 1, 0, 0));
    vt.push_back(V(0, 0, a, 4'h0, 0, 1, 0, 0));                       // written-back data
    vt.push_back(V(1, 0, mk(T1, 9, 4'h4), 4'b1000, 32'h7700_0000, 1, 0, 0)); // store miss
    vt.push_back(V(0, 0, mk(T1, 9, 4'h4), 4'h0, 0, 0, 0, 0));
    vt.push_back(V(0, 0, mk(T2, 9, 4'h0), 4'h0, 0, 1, 0, 0));
    vt.push_back(V(0, 0, mk(T3, 9, 4'h0), 4'h0, 0, 1, 0, 0));
    vt.push_back(V(0, 0, mk(T4, 9, 4'h0), 4'h0, 0, 1, 0, 0));
    vt.push_back(V(0, 0, mk(T5, 9, 4'h0), 4'h0, 0, 1, 1, mk(T1, 9, 0))); // dirty from store miss
    vt.push_back(V(0, 0, mk(T1, 9, 4'h4), 4'h0, 0, 1, 0, 0));
    vt.push_back(V(1, 1, ua, 4'b0101, 32'h1234_5678, 0, 1, ua));      // uncached store
    vt.push_back(V(0, 1, ua, 4'h0, 0, 1, 0, 0));                      // uncached load
    vt.push_back(V(0, 0, ua, 4'h0, 0, 1, 0, 0));                      // not allocated by uncached
    vt.push_back(V(0, 0, ua, 4'h0, 0, 0, 0, 0));
    vt.push_back(V(0, 1, ua, 4'h0, 0, 1, 0, 0));                      // uncached never hits

    foreach (vt[i]) run_vec(vt[i], $sformatf("v%0d", i));

    // reset while the second refill beat is on the bus
    k = 0;
    while (bus.addr_ok !== 1'b1 && k < 100) begin @(posedge clk); #1; k++; end
    bus.valid = 1'b1; bus.op = 1'b0; bus.uncached = 1'b0;
    bus.tag = 22'h00666; bus.index = 6'd5; bus.offset = 4'hC;
    @(posedge clk); #1 bus.valid = 1'b0;
    k = 0;
    while (beat_i != 2 && k < 50) begin @(negedge clk); #1; k++; end
    chk("abort reached beat 1", beat_i, 2);
    reset = 1'b1;
    #1;
    chk("abort addr_ok", bus.addr_ok, 1'b1);
    chk("abort data_ok", bus.data_ok, 1'b0);
    chk("abort rd_req", bus.rd_req, 1'b0);
    chk("abort wr_req", bus.wr_req, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1 reset = 1'b0;
    run_vec(V(0, 0, mk(T4, 5, 4'h0), 4'h0, 0, 1, 0, 0), "post-reset T4");
    run_vec(V(0, 0, a, 4'h0, 0, 1, 0, 0), "post-reset A");
    run_vec(V(0, 0, mk(T4, 5, 4'h0), 4'h0, 0, 0, 0, 0), "post-reset T4 hit");

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
